sram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port DPI-backed main-memory SRAM. Port 0 (instruction fetch) and port 1 (load/store unit) each issue valid/ready requests. The block grants one request per issue slot with round-robin priority, drives the SRAM enable/write strobes, and returns the read data to the granted port on a valid/ready response channel. It sits between the core front-end/LSU and the SRAM model in the NPC top level.

---
 rtl/sram_arbiter.sv | 85 ++++++++
 tb/tb_sram_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and sequencer between two valid/ready requesters and a
// single-port SRAM; each grant yields one response on the granted port.
module sram_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        p0_req_valid,
   output logic        p0_req_ready,
   input  logic [31:0] p0_req_addr,
   input  logic        p0_req_wen,
   input  logic [31:0] p0_req_wdata,
   input  logic [7:0]  p0_req_wmask,
   output logic        p0_resp_valid,
   input  logic        p0_resp_ready,
   output logic [31:0] p0_resp_rdata,
   input  logic        p1_req_valid,
   output logic        p1_req_ready,
   input  logic [31:0] p1_req_addr,
   input  logic        p1_req_wen,
   input  logic [31:0] p1_req_wdata,
   input  logic [7:0]  p1_req_wmask,
   output logic        p1_resp_valid,
   input  logic        p1_resp_ready,
   output logic [31:0] p1_resp_rdata,
   output logic        sram_ena,
   output logic        sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   output logic [7:0]  sram_wmask,
   input  logic [31:0] sram_rdata
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t state_q, state_d;
   logic   own_q, own_d;
   logic   last_q, last_d;
   logic   fire, slot, win, grant;

   always_comb begin
      fire  = (state_q == RESP) && (own_q ? p1_resp_ready : p0_resp_ready);
      // No issue slot while reset is high, so the reset cycle never touches the SRAM.
      slot  = !reset && ((state_q == IDLE) || fire);
      win   = (p0_req_valid && p1_req_valid) ? ~last_q : p1_req_valid;
      grant = slot && (p0_req_valid || p1_req_valid);

      state_d = state_q;
      own_d   = own_q;
      last_d  = last_q;
      if (grant) begin
         state_d = RESP;
         own_d   = win;
         last_d  = win;
      end else if (fire) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         own_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         last_q  <= last_d;
      end
   end

   assign p0_req_ready = grant && !win;
   assign p1_req_ready = grant && win;

   assign sram_ena   = grant;
   assign sram_wen   = grant && (win ? p1_req_wen : p0_req_wen);
   assign sram_addr  = (grant && win) ? p1_req_addr  : p0_req_addr;
   assign sram_wdata = (grant && win) ? p1_req_wdata : p0_req_wdata;
   assign sram_wmask = (grant && win) ? p1_req_wmask : p0_req_wmask;

   // The SRAM is idle while a response waits, so its read port holds the data.
   assign p0_resp_valid = !reset && (state_q == RESP) && !own_q;
   assign p1_resp_valid = !reset && (state_q == RESP) && own_q;
   assign p0_resp_rdata = sram_rdata;
   assign p1_resp_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, queue-based scoreboard checked
// every cycle, directed scenarios followed by randomized stress.
module tb_sram_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        p0_req_valid, p0_req_ready, p0_req_wen;
   logic [31:0] p0_req_addr, p0_req_wdata, p0_resp_rdata;
   logic [7:0]  p0_req_wmask;
   logic        p0_resp_valid, p0_resp_ready;
   logic        p1_req_valid, p1_req_ready, p1_req_wen;
   logic [31:0] p1_req_addr, p1_req_wdata, p1_resp_rdata;
   logic [7:0]  p1_req_wmask;
   logic        p1_resp_valid, p1_resp_ready;
   logic        sram_ena, sram_wen;
   logic [31:0] sram_addr, sram_wdata;
   logic [7:0]  sram_wmask;
   logic [31:0] sram_rdata = 32'h0;

   int checks = 0;
   int errors = 0;

   sram_arbiter dut (
      .clock(clock), .reset(reset),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
      .p0_req_addr(p0_req_addr), .p0_req_wen(p0_req_wen),
      .p0_req_wdata(p0_req_wdata), .p0_req_wmask(p0_req_wmask),
      .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready),
      .p0_resp_rdata(p0_resp_rdata),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
      .p1_req_addr(p1_req_addr), .p1_req_wen(p1_req_wen),
      .p1_req_wdata(p1_req_wdata), .p1_req_wmask(p1_req_wmask),
      .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready),
      .p1_resp_rdata(p1_resp_rdata),
      .sram_ena(sram_ena), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
   );

   always #5 clock = ~clock;

   // Unwritten words read back as a fixed function of their address.
   function automatic logic [31:0] init_word(input logic [29:0] k);
      return {k[13:0], 2'b01, k[15:0]} ^ 32'hA5C3_5A3C;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [7:0] m);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++)
         if (m[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // Behavioural SRAM: read-before-write on every enabled edge.
   logic [31:0] sram_mem [logic [29:0]];
   always @(posedge clock) begin
      if (sram_ena) begin
         logic [31:0] cur;
         cur = sram_mem.exists(sram_addr[31:2]) ? sram_mem[sram_addr[31:2]] : init_word(sram_addr[31:2]);
         sram_rdata <= cur;
         if (sram_wen) sram_mem[sram_addr[31:2]] = merge(cur, sram_wdata, sram_wmask);
      end
   end

   // Scoreboard: reference memory, queue of outstanding responses, last winner.
   typedef struct { int port; logic [31:0] data; } resp_t;
   logic [31:0] ref_mem [logic [29:0]];
   resp_t       pendq[$];
   int          m_last = 1;
   int          n_req = 0;
   int          n_resp = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      bit          v0, v1, fire, slot;
      int          w;
      logic [31:0] a, d, cur;
      logic [7:0]  m;
      logic        we;
      v0 = !reset && pendq.size() > 0 && pendq[0].port == 0;
      v1 = !reset && pendq.size() > 0 && pendq[0].port == 1;
      chk("p0_resp_valid", {31'b0, p0_resp_valid}, {31'b0, v0});
      chk("p1_resp_valid", {31'b0, p1_resp_valid}, {31'b0, v1});
      if (v0) chk("p0_resp_rdata", p0_resp_rdata, pendq[0].data);
      if (v1) chk("p1_resp_rdata", p1_resp_rdata, pendq[0].data);
      fire = (v0 && p0_resp_ready) || (v1 && p1_resp_ready);
      slot = !reset && (pendq.size() == 0 || fire);
      w = -1;
      if (slot) begin
         if (p0_req_valid && p1_req_valid) w = 1 - m_last;
         else if (p0_req_valid) w = 0;
         else if (p1_req_valid) w = 1;
      end
      we = (w == 0) ? p0_req_wen : (w == 1) ? p1_req_wen : 1'b0;
      chk("p0_req_ready", {31'b0, p0_req_ready}, {31'b0, w == 0});
      chk("p1_req_ready", {31'b0, p1_req_ready}, {31'b0, w == 1});
      chk("sram_ena", {31'b0, sram_ena}, {31'b0, w >= 0});
      chk("sram_wen", {31'b0, sram_wen}, {31'b0, we});
      if (w >= 0) begin
         a = (w == 0) ? p0_req_addr  : p1_req_addr;
         d = (w == 0) ? p0_req_wdata : p1_req_wdata;
         m = (w == 0) ? p0_req_wmask : p1_req_wmask;
         chk("sram_addr", sram_addr, a);
         chk("sram_wdata", sram_wdata, d);
         chk("sram_wmask", {24'b0, sram_wmask}, {24'b0, m});
      end
      if (reset) begin
         pendq.delete();
         m_last = 1;
      end else begin
         if (fire) begin
            void'(pendq.pop_front());
            n_resp++;
         end
         if (w >= 0) begin
            cur = ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a[31:2]);
            pendq.push_back('{port: w, data: cur});
            if (we) ref_mem[a[31:2]] = merge(cur, d, m);
            m_last = w;
            n_req++;
         end
      end
   endtask

   // Inputs are driven just after a falling edge; outputs are checked 1 ns later.
   task automatic tick();
      #1 step();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      p0_req_valid = 0; p0_req_addr = 0; p0_req_wen = 0; p0_req_wdata = 0; p0_req_wmask = 0;
      p1_req_valid = 0; p1_req_addr = 0; p1_req_wen = 0; p1_req_wdata = 0; p1_req_wmask = 0;
      p0_resp_ready = 1; p1_resp_ready = 1;
   endtask

   initial begin
      logic [31:0] held;
      reset = 1;
      idle_inputs();
      sram_mem[30'h2000_0000] = 32'hDEADBEEF;
      ref_mem[30'h2000_0000]  = 32'hDEADBEEF;
      @(negedge clock);
      tick();
      tick();
      reset = 0;

      // Single read
      p0_req_valid = 1; p0_req_addr = 32'h8000_0000;
      tick();
      p0_req_valid = 0;
      chk("single_read_valid", {31'b0, p0_resp_valid}, 32'd1);
      chk("single_read_data", p0_resp_rdata, 32'hDEADBEEF);
      tick();

      // Write then read back on port 1
      p1_req_valid = 1; p1_req_addr = 32'h8000_0010; p1_req_wen = 1;
      p1_req_wdata = 32'h1234_5678; p1_req_wmask = 8'h0F;
      tick();
      p1_req_wen = 0; p1_req_wdata = 0; p1_req_wmask = 0;
      chk("write_resp_old", p1_resp_rdata, init_word(30'h2000_0004));
      tick();
      p1_req_valid = 0;
      chk("read_back", p1_resp_rdata, 32'h1234_5678);
      tick();

      // Conflict right after reset alternates p0, p1, p0, p1
      reset = 1;
      tick();
      reset = 0;
      p0_req_valid = 1; p0_req_addr = 32'h8000_0004;
      p1_req_valid = 1; p1_req_addr = 32'h8000_0008;
      for (int i = 0; i < 4; i++) begin
         #1 chk("conflict_p0_grant", {31'b0, p0_req_ready}, {31'b0, (i % 2) == 0});
         tick();
      end
      p0_req_valid = 0; p1_req_valid = 0;
      tick();

      // Backpressure on port 0 stalls port 1
      p0_req_valid = 1; p0_req_addr = 32'h8000_0000; p0_resp_ready = 0;
      tick();
      p0_req_valid = 0;
      p1_req_valid = 1; p1_req_addr = 32'h8000_0010;
      held = p0_resp_rdata;
      for (int i = 0; i < 5; i++) begin
         #1 chk("stall_p1_ready", {31'b0, p1_req_ready}, 32'd0);
         chk("stall_rdata", p0_resp_rdata, held);
         tick();
      end
      p0_resp_ready = 1;
      #1 chk("release_p1_ready", {31'b0, p1_req_ready}, 32'd1);
      tick();
      p1_req_valid = 0;
      tick();

      // Reset while a response is outstanding
      p0_req_valid = 1; p0_req_addr = 32'h8000_0000; p0_resp_ready = 0;
      tick();
      p0_req_valid = 0; reset = 1;
      tick();
      reset = 0; p0_resp_ready = 1;
      chk("post_reset_p0_valid", {31'b0, p0_resp_valid}, 32'd0);
      p1_req_valid = 1; p1_req_addr = 32'h8000_0010;
      tick();
      p1_req_valid = 0;
      chk("post_reset_p1_data", p1_resp_rdata, 32'h1234_5678);
      tick();

      // Randomized stress
      for (int c = 0; c < 10000; c++) begin
         reset         = ($urandom_range(0, 499) == 0);
         p0_req_valid  = ($urandom_range(0, 99) < 60);
         p1_req_valid  = ($urandom_range(0, 99) < 60);
         p0_req_addr   = 32'h8000_0000 + ($urandom_range(0, 15) << 2);
         p1_req_addr   = 32'h8000_0000 + ($urandom_range(0, 15) << 2);
         p0_req_wen    = $urandom_range(0, 1) == 1;
         p1_req_wen    = $urandom_range(0, 1) == 1;
         p0_req_wdata  = $urandom;
         p1_req_wdata  = $urandom;
         p0_req_wmask  = 8'($urandom);
         p1_req_wmask  = 8'($urandom);
         p0_resp_ready = ($urandom_range(0, 99) < 70);
         p1_resp_ready = ($urandom_range(0, 99) < 70);
         tick();
      end
      reset = 0;
      idle_inputs();
      tick();
      tick();
      chk("drained", pendq.size(), 32'd0);
      $display("transactions requested=%0d responded=%0d", n_req, n_resp);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
